yrv_input_conditioner: RTL
==========================

Name: yrv_input_conditioner

Overview:
- Front-end conditioner between raw board pins (push-buttons, DIP switches, NMI button) and the yrv_mcu inputs port4_in, ei_req and nmi_req.
- Synchronises each asynchronous pin, debounces it, and presents stable levels for a port input.
- Latches debounced rising edges as sticky, maskable interrupt-pending bits that drive ei_req.
- Converts the active-low NMI button into a single-cycle nmi_req pulse.

Parameters:
N_KEYS, 16, number of key/switch channels (1..16).
DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synced input must differ from its debounced value before the debounced value flips (20 ms at 50 MHz); minimum 2.
SYNC_STAGES, 2, synchroniser flop depth (minimum 2).

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high reset
keys_raw  input  N_KEYS  raw asynchronous key/switch pins, active-high
nmi_raw_n  input  1  raw asynchronous NMI button, active-low
int_mask  input  N_KEYS  per-channel interrupt enable, 1 = enabled
int_clr  input  N_KEYS  write-1-to-clear strobe for int_pending, one cycle per clear
keys_db  output  N_KEYS  debounced key levels, to port4_in
int_pending  output  N_KEYS  sticky rising-edge flags
ei_req  output  1  external interrupt request to the MCU, level
nmi_req  output  1  one-cycle NMI request pulse

Behaviour:
- Reset, asynchronous and active-high:
  - Key synchroniser flops, keys_db, int_pending, ei_req, nmi_req and all debounce counters clear to 0.
  - The NMI synchroniser flops and the debounced NMI level reset to 1 (inactive), so releasing reset never produces an NMI.
  - Assertion mid-debounce aborts the count; no output glitches on release.
- Synchronisation: each channel passes through a SYNC_STAGES flop chain. No logic is placed between the stages.
- Debounce, per channel:
  - The counter increments while synced != debounced and clears to 0 whenever synced == debounced.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced value inverts, the counter clears, and a one-cycle flip strobe fires.
  - Any disagreement shorter than DEBOUNCE_CYCLES cycles has no effect.
  - Latency from a clean pin change to the debounced output is SYNC_STAGES + DEBOUNCE_CYCLES cycles, with +1 of asynchronous sampling uncertainty.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). The counter saturates and never wraps.
- Edge latch:
  - int_pending[i] sets on the same clk edge that keys_db[i] goes 0->1. Masked channels still latch.
  - int_clr[i] clears the bit. If set and clear coincide, set wins.
  - Falling edges never set pending.
- ei_req is registered: ei_req <= |(int_pending & int_mask). It follows pending/mask changes with a 1-cycle delay and stays high until every enabled pending bit is cleared or masked.
- NMI:
  - A debounced 1->0 transition of nmi_raw_n drives nmi_req high for exactly one cycle, registered on the edge after the flip.
  - Holding the button produces no further pulses; the button must be released (debounced) and pressed again.
- Unused upper bits (N_KEYS < 16): the integrating top level zero-extends them. This block does not pad.

Decomposition:
- Package yrv_input_pkg: default constants CLK_FREQ_HZ = 50_000_000, DEBOUNCE_MS = 20, derived DEBOUNCE_CYCLES_DEFAULT, and a function computing the counter width.
- Sub-module yrv_debounce_bit:
  - Parameters: SYNC_STAGES, DEBOUNCE_CYCLES, RESET_VALUE.
  - Ports: clk, reset, raw, db, rise, fall.
  - Instantiated N_KEYS times via generate, plus once with RESET_VALUE = 1 for NMI.
  - The top holds the pending register, the ei_req flop and the nmi pulse logic.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 8, SYNC_STAGES = 2, N_KEYS = 16.
- Reset: hold reset with keys_raw = 16'hFFFF and nmi_raw_n = 0 -> all outputs 0 during reset. Release with nmi_raw_n = 1 -> nmi_req stays 0 for 50 cycles.
- Clean press: keys_raw[3] 0->1 held, int_mask = 16'h0008 -> keys_db[3] rises 10 (+1) cycles later; int_pending = 16'h0008 on the same edge; ei_req = 1 one cycle later.
- Glitch and bounce: keys_raw[0] high for 5 cycles -> no change. Toggling every 3 cycles for 30 cycles then settling high -> exactly one keys_db[0] rise and one pending set.
- Clear and collision: int_clr = 16'h0008 pulse -> int_pending = 0, ei_req falls next cycle. A clear coincident with a new rise on bit 3 -> bit 3 stays 1. Masked bit 5 rise -> pending[5] = 1, ei_req stays 0.
- NMI: nmi_raw_n low for 100 cycles -> exactly one single-cycle nmi_req pulse. Release, settle, press again -> a second single pulse.
- Reset mid-operation: assert reset 4 cycles into a debounce count -> counter aborts. After release, a fresh full 10-cycle latency applies.

Source files
------------

// File: rtl/yrv_input_pkg.sv
// Shared constants and helpers for the yrv board input conditioner.
package yrv_input_pkg;

    localparam int unsigned CLK_FREQ_HZ = 50_000_000;
    localparam int unsigned DEBOUNCE_MS = 20;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT =
        (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/yrv_debounce_bit.sv
// One pin: synchroniser chain, integrating debouncer, flip strobes.
module yrv_debounce_bit
    import yrv_input_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic        RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   flip;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        flip  = 1'b0;
        if (synced == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            flip  = 1'b1;
            db_d  = ~db_q;
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
            cnt_q  <= '0;
            db_q   <= RESET_VALUE;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

    // Strobes lead db by one cycle so a consumer flop lands on the flip edge.
    assign db   = db_q;
    assign rise = flip & ~db_q;
    assign fall = flip & db_q;

endmodule

// File: rtl/yrv_input_conditioner.sv
// Debounced key levels, sticky maskable key interrupts and NMI pulse.
module yrv_input_conditioner
    import yrv_input_pkg::*;
#(
    parameter int unsigned N_KEYS          = 16,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keys_raw,
    input  logic              nmi_raw_n,
    input  logic [N_KEYS-1:0] int_mask,
    input  logic [N_KEYS-1:0] int_clr,
    output logic [N_KEYS-1:0] keys_db,
    output logic [N_KEYS-1:0] int_pending,
    output logic              ei_req,
    output logic              nmi_req
);

    logic [N_KEYS-1:0] key_rise;
    logic [N_KEYS-1:0] key_fall_unused;
    logic [N_KEYS-1:0] pending_q, pending_d;
    logic              ei_q;
    logic              nmi_fall;
    logic              nmi_db_unused;
    logic              nmi_rise_unused;
    logic              nmi_fall_q;
    logic              nmi_req_q;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        yrv_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (1'b0)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (keys_raw[i]),
            .db    (keys_db[i]),
            .rise  (key_rise[i]),
            .fall  (key_fall_unused[i])
        );
    end

    // Idles high through reset so releasing reset cannot fake a press.
    yrv_debounce_bit #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VALUE     (1'b1)
    ) u_nmi (
        .clk   (clk),
        .reset (reset),
        .raw   (nmi_raw_n),
        .db    (nmi_db_unused),
        .rise  (nmi_rise_unused),
        .fall  (nmi_fall)
    );

    always_comb begin
        pending_d = (pending_q & ~int_clr) | key_rise;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q  <= '0;
            ei_q       <= 1'b0;
            nmi_fall_q <= 1'b0;
            nmi_req_q  <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            ei_q       <= |(pending_q & int_mask);
            nmi_fall_q <= nmi_fall;
            nmi_req_q  <= nmi_fall_q;
        end
    end

    assign int_pending = pending_q;
    assign ei_req      = ei_q;
    assign nmi_req     = nmi_req_q;

endmodule
